imem_loader: RTL

//  Write-side partner of instruction fetch: a boot loader that takes a byte stream (valid/ready),

---
 rtl/imem_loader.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Boot loader: packs a length-prefixed byte stream into 32-bit little-endian words
// and writes them to instruction memory, holding the CPU in reset until the image is loaded.
module imem_loader #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned BASE_ADDR  = 0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   input  logic                  start,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error
);

   typedef enum logic [2:0] {
      S_LEN_LO = 3'd0,
      S_LEN_HI = 3'd1,
      S_DATA   = 3'd2,
      S_WRITE  = 3'd3,
      S_DONE   = 3'd4,
      S_ERROR  = 3'd5
   } state_t;

   localparam logic [16:0]           DEPTH_C = 17'd1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] BASE_C  = BASE_ADDR[ADDR_WIDTH-1:0];

   state_t                state_q, state_d;
   logic [15:0]           len_q, len_d;
   logic [1:0]            byte_idx_q, byte_idx_d;
   logic [23:0]           word_q, word_d;
   logic [ADDR_WIDTH:0]   words_q, words_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]           mem_wdata_q, mem_wdata_d;
   logic                  in_ready_q, in_ready_d;
   logic                  cpu_hold_q, cpu_hold_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;

   logic                  accept_s;
   logic [16:0]           len_new_s;
   logic [ADDR_WIDTH:0]   words_inc_s;
   logic [16:0]           words_ext_s;

   assign accept_s    = in_valid & in_ready_q;
   assign len_new_s   = {1'b0, in_data, len_q[7:0]};
   assign words_inc_s = words_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
   assign words_ext_s = 17'(words_inc_s);

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      byte_idx_d  = byte_idx_q;
      word_d      = word_q;
      words_d     = words_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         S_LEN_LO: begin
            if (accept_s) begin
               len_d[7:0] = in_data;
               state_d    = S_LEN_HI;
            end else begin
               state_d = S_LEN_LO;
            end
         end
         S_LEN_HI: begin
            if (accept_s) begin
               len_d[15:8] = in_data;
               if (len_new_s == 17'd0) begin
                  state_d = S_DONE;
               end else if (len_new_s > DEPTH_C) begin
                  state_d = S_ERROR;
               end else begin
                  state_d = S_DATA;
               end
            end else begin
               state_d = S_LEN_HI;
            end
         end
         S_DATA: begin
            if (accept_s) begin
               byte_idx_d = byte_idx_q + 2'd1;
               case (byte_idx_q)
                  2'd0: word_d[7:0]   = in_data;
                  2'd1: word_d[15:8]  = in_data;
                  2'd2: word_d[23:16] = in_data;
                  default: begin
                     // Last byte goes straight into the write word; no need to buffer it
                     mem_we_d    = 1'b1;
                     mem_wdata_d = {in_data, word_q};
                     mem_addr_d  = BASE_C + words_q[ADDR_WIDTH-1:0];
                     state_d     = S_WRITE;
                  end
               endcase
            end else begin
               state_d = S_DATA;
            end
         end
         S_WRITE: begin
            words_d    = words_inc_s;
            byte_idx_d = 2'd0;
            if (words_ext_s == {1'b0, len_q}) begin
               state_d = S_DONE;
            end else begin
               state_d = S_DATA;
            end
         end
         S_DONE, S_ERROR: begin
            if (start) begin
               state_d    = S_LEN_LO;
               len_d      = 16'd0;
               byte_idx_d = 2'd0;
               word_d     = 24'd0;
               words_d    = '0;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = S_LEN_LO;
         end
      endcase
      in_ready_d = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) || (state_d == S_DATA);
      cpu_hold_d = (state_d != S_DONE);
      done_d     = (state_d == S_DONE);
      error_d    = (state_d == S_ERROR);
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= S_LEN_LO;
         len_q       <= 16'd0;
         byte_idx_q  <= 2'd0;
         word_q      <= 24'd0;
         words_q     <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 32'd0;
         in_ready_q  <= 1'b0;
         cpu_hold_q  <= 1'b1;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         byte_idx_q  <= byte_idx_d;
         word_q      <= word_d;
         words_q     <= words_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         in_ready_q  <= in_ready_d;
         cpu_hold_q  <= cpu_hold_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_hold  = cpu_hold_q;
   assign done      = done_q;
   assign error     = error_q;

endmodule
